rvvi_retire_tracer: RTL and testbench

Producer side of the RVVI trace for a single hart. Accepts one retirement record per cycle from the core's commit stage over a valid/ready handshake, buffers it in a small FIFO, assigns the gap-free `order` count, and drives RVVI-shaped outputs. X/F register state is driven from shadow register files, so `x_wdata`/`f_wdata` always carry full architectural state, as the coverage side expects. CSRs, vector registers, interrupts and the DM are out of scope.

---
 rtl/rvvi_retire_tracer.sv | 174 +++++++++++++++++
 tb/tb_rvvi_retire_tracer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_retire_tracer.sv
// RVVI trace producer for one hart: buffers commit-stage retire records, numbers them,
// and presents registered RVVI outputs backed by X/F shadow register files.
module rvvi_retire_tracer #(
  parameter int unsigned ILEN     = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ret_valid,
  output logic                     ret_ready,
  input  logic [ILEN-1:0]          ret_insn,
  input  logic [XLEN-1:0]          ret_pc,
  input  logic [XLEN-1:0]          ret_next_pc,
  input  logic                     ret_trap,
  input  logic [1:0]               ret_mode,
  input  logic                     ret_rd_we,
  input  logic [4:0]               ret_rd,
  input  logic [XLEN-1:0]          ret_rd_data,
  input  logic                     ret_fd_we,
  input  logic [4:0]               ret_fd,
  input  logic [FLEN-1:0]          ret_fd_data,
  input  logic                     trace_stall,
  output logic                     valid,
  output logic [63:0]              order,
  output logic [ILEN-1:0]          insn,
  output logic                     trap,
  output logic [XLEN-1:0]          pc_rdata,
  output logic [XLEN-1:0]          pc_wdata,
  output logic [1:0]               mode,
  output logic [NUM_REGS*XLEN-1:0] x_wdata,
  output logic [NUM_REGS-1:0]      x_wb,
  output logic [32*FLEN-1:0]       f_wdata,
  output logic [31:0]              f_wb
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned XIDX_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            trap;
    logic [1:0]      mode;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            fd_we;
    logic [4:0]      fd;
    logic [FLEN-1:0] fd_data;
  } rec_t;

  rec_t                          mem_q [DEPTH];
  logic [PTR_W-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          valid_q, valid_d;
  logic [63:0]                   order_q, order_d;
  logic [ILEN-1:0]               insn_q, insn_d;
  logic                          trap_q, trap_d;
  logic [XLEN-1:0]               pc_rdata_q, pc_rdata_d, pc_wdata_q, pc_wdata_d;
  logic [1:0]                    mode_q, mode_d;
  logic [NUM_REGS-1:0]           x_wb_q, x_wb_d;
  logic [31:0]                   f_wb_q, f_wb_d;
  logic [NUM_REGS-1:0][XLEN-1:0] x_q, x_d;
  logic [31:0][FLEN-1:0]         f_q, f_d;

  rec_t              in_rec, emit_rec;
  logic              push, pop, bypass, store, emit, have_head;
  logic [XIDX_W-1:0] x_idx;

  // Ready reflects occupancy only; a same-cycle pop does not free a slot early.
  assign ret_ready = !reset && (count_q < CNT_W'(DEPTH));

  always_comb begin
    in_rec     = '{insn: ret_insn, pc: ret_pc, next_pc: ret_next_pc, trap: ret_trap,
                   mode: ret_mode, rd_we: ret_rd_we, rd: ret_rd, rd_data: ret_rd_data,
                   fd_we: ret_fd_we, fd: ret_fd, fd_data: ret_fd_data};
    push       = ret_valid && ret_ready;
    have_head  = (count_q != '0);
    pop        = have_head && !trace_stall;
    bypass     = !have_head && push && !trace_stall;
    store      = push && !bypass;
    emit       = pop || bypass;
    emit_rec   = have_head ? mem_q[rptr_q] : in_rec;
    x_idx      = emit_rec.rd[XIDX_W-1:0];

    wptr_d     = store ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PTR_W'(1) : rptr_q;
    count_d    = count_q + CNT_W'(store) - CNT_W'(pop);
    valid_d    = 1'b0;
    order_d    = order_q;
    insn_d     = insn_q;
    trap_d     = trap_q;
    pc_rdata_d = pc_rdata_q;
    pc_wdata_d = pc_wdata_q;
    mode_d     = mode_q;
    x_wb_d     = '0;
    f_wb_d     = '0;
    x_d        = x_q;
    f_d        = f_q;

    // Emit: load record fields, number it, and fold its writebacks into the shadows.
    if (emit) begin
      valid_d    = 1'b1;
      order_d    = order_q + 64'd1;
      insn_d     = emit_rec.insn;
      trap_d     = emit_rec.trap;
      pc_rdata_d = emit_rec.pc;
      pc_wdata_d = emit_rec.next_pc;
      mode_d     = emit_rec.mode;
      if (!emit_rec.trap && emit_rec.rd_we && (x_idx != '0)) begin
        x_d[x_idx]    = emit_rec.rd_data;
        x_wb_d[x_idx] = 1'b1;
      end
      if (!emit_rec.trap && emit_rec.fd_we) begin
        f_d[emit_rec.fd]    = emit_rec.fd_data;
        f_wb_d[emit_rec.fd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      order_q    <= '0;
      insn_q     <= '0;
      trap_q     <= 1'b0;
      pc_rdata_q <= '0;
      pc_wdata_q <= '0;
      mode_q     <= '0;
      x_wb_q     <= '0;
      f_wb_q     <= '0;
      x_q        <= '0;
      f_q        <= '0;
    end else begin
      if (store) mem_q[wptr_q] <= in_rec;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      order_q    <= order_d;
      insn_q     <= insn_d;
      trap_q     <= trap_d;
      pc_rdata_q <= pc_rdata_d;
      pc_wdata_q <= pc_wdata_d;
      mode_q     <= mode_d;
      x_wb_q     <= x_wb_d;
      f_wb_q     <= f_wb_d;
      x_q        <= x_d;
      f_q        <= f_d;
    end
  end

  assign valid    = valid_q;
  assign order    = order_q;
  assign insn     = insn_q;
  assign trap     = trap_q;
  assign pc_rdata = pc_rdata_q;
  assign pc_wdata = pc_wdata_q;
  assign mode     = mode_q;
  assign x_wb     = x_wb_q;
  assign f_wb     = f_wb_q;
  assign x_wdata  = x_q;
  assign f_wdata  = f_q;

endmodule

// File: tb/tb_rvvi_retire_tracer.sv
// Directed bench for rvvi_retire_tracer: ordering, FIFO backpressure, write filtering,
// dual writes and asynchronous reset, with hand-computed expectations.
module tb_rvvi_retire_tracer;

  localparam int unsigned ILEN = 32, XLEN = 32, FLEN = 32, NUM_REGS = 32, DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     ret_valid, ret_ready;
  logic [ILEN-1:0]          ret_insn;
  logic [XLEN-1:0]          ret_pc, ret_next_pc;
  logic                     ret_trap;
  logic [1:0]               ret_mode;
  logic                     ret_rd_we;
  logic [4:0]               ret_rd;
  logic [XLEN-1:0]          ret_rd_data;
  logic                     ret_fd_we;
  logic [4:0]               ret_fd;
  logic [FLEN-1:0]          ret_fd_data;
  logic                     trace_stall;
  logic                     valid;
  logic [63:0]              order;
  logic [ILEN-1:0]          insn;
  logic                     trap;
  logic [XLEN-1:0]          pc_rdata, pc_wdata;
  logic [1:0]               mode;
  logic [NUM_REGS*XLEN-1:0] x_wdata;
  logic [NUM_REGS-1:0]      x_wb;
  logic [32*FLEN-1:0]       f_wdata;
  logic [31:0]              f_wb;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_order = 64'd0;

  rvvi_retire_tracer #(.ILEN(ILEN), .XLEN(XLEN), .FLEN(FLEN), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_insn(ret_insn), .ret_pc(ret_pc), .ret_next_pc(ret_next_pc), .ret_trap(ret_trap),
    .ret_mode(ret_mode), .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_data(ret_rd_data),
    .ret_fd_we(ret_fd_we), .ret_fd(ret_fd), .ret_fd_data(ret_fd_data),
    .trace_stall(trace_stall), .valid(valid), .order(order), .insn(insn), .trap(trap),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .mode(mode), .x_wdata(x_wdata), .x_wb(x_wb),
    .f_wdata(f_wdata), .f_wb(f_wb)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] xreg(input int i);
    return x_wdata[i*XLEN +: XLEN];
  endfunction

  function automatic logic [FLEN-1:0] freg(input int i);
    return f_wdata[i*FLEN +: FLEN];
  endfunction

  // Advance to just after the next rising edge; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [31:0] i_insn, input logic [31:0] i_pc, input logic i_trap,
                         input logic i_rd_we, input logic [4:0] i_rd, input logic [31:0] i_rd_data,
                         input logic i_fd_we, input logic [4:0] i_fd, input logic [31:0] i_fd_data);
    ret_valid   = 1'b1;
    ret_insn    = i_insn;
    ret_pc      = i_pc;
    ret_next_pc = i_pc + 32'd4;
    ret_trap    = i_trap;
    ret_mode    = 2'd3;
    ret_rd_we   = i_rd_we;
    ret_rd      = i_rd;
    ret_rd_data = i_rd_data;
    ret_fd_we   = i_fd_we;
    ret_fd      = i_fd;
    ret_fd_data = i_fd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; ret_valid = 1'b0; trace_stall = 1'b0;
    ret_insn = '0; ret_pc = '0; ret_next_pc = '0; ret_trap = 1'b0; ret_mode = '0;
    ret_rd_we = 1'b0; ret_rd = '0; ret_rd_data = '0; ret_fd_we = 1'b0; ret_fd = '0; ret_fd_data = '0;
    tick(); tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid); end
    checks++; if (order !== 64'd0) begin errors++; $display("FAIL reset_order got %0h exp 0", order); end
    checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0h exp 0", ret_ready); end
    checks++; if (x_wdata !== '0 || f_wdata !== '0) begin errors++; $display("FAIL reset_shadow got x=%0h f=%0h exp 0", x_wdata, f_wdata); end
    checks++; if (x_wb !== '0 || f_wb !== '0 || insn !== '0 || pc_rdata !== '0) begin errors++; $display("FAIL reset_fields got xwb=%0h fwb=%0h insn=%0h pc=%0h exp 0", x_wb, f_wb, insn, pc_rdata); end
    reset = 1'b0;
    #1;
    checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0h exp 1", ret_ready); end
  endtask

  task automatic test_single();
    set_rec(32'h00500093, 32'h80000000, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0, 32'd0);
    tick();
    ret_valid = 1'b0;
    exp_order = 64'd1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", valid); end
    checks++; if (order !== 64'd1) begin errors++; $display("FAIL single_order got %0h exp 1", order); end
    checks++; if (x_wb !== 32'h2) begin errors++; $display("FAIL single_xwb got %0h exp 2", x_wb); end
    checks++; if (xreg(1) !== 32'd5) begin errors++; $display("FAIL single_x1 got %0h exp 5", xreg(1)); end
    checks++; if (insn !== 32'h00500093 || pc_rdata !== 32'h80000000 || pc_wdata !== 32'h80000004 || mode !== 2'd3 || trap !== 1'b0)
      begin errors++; $display("FAIL single_fields got insn=%0h pc=%0h npc=%0h mode=%0h trap=%0h exp 500093/80000000/80000004/3/0", insn, pc_rdata, pc_wdata, mode, trap); end
    tick();
    checks++; if (valid !== 1'b0 || x_wb !== '0) begin errors++; $display("FAIL single_pulse got valid=%0h xwb=%0h exp 0/0", valid, x_wb); end
    checks++; if (order !== 64'd1 || insn !== 32'h00500093) begin errors++; $display("FAIL single_hold got order=%0h insn=%0h exp 1/500093", order, insn); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0h exp 1", i, ret_ready); end
      set_rec(32'h00000013 + 32'(i), 32'h80001000 + 32'(4*i), 1'b0, 1'b1, 5'(i+1), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
      tick();
      exp_order = exp_order + 64'd1;
      checks++; if (valid !== 1'b1 || order !== exp_order) begin errors++; $display("FAIL b2b_emit[%0d] got valid=%0h order=%0h exp 1/%0h", i, valid, order, exp_order); end
      checks++; if (x_wb !== (32'h1 << (i+1))) begin errors++; $display("FAIL b2b_xwb[%0d] got %0h exp %0h", i, x_wb, 32'h1 << (i+1)); end
    end
    ret_valid = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0h exp 0", valid); end
    checks++; if (xreg(1) !== 32'h100 || xreg(10) !== 32'h109) begin errors++; $display("FAIL b2b_shadow got x1=%0h x10=%0h exp 100/109", xreg(1), xreg(10)); end
  endtask

  task automatic test_full_drain();
    trace_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (ret_ready !== (k < 4)) begin errors++; $display("FAIL full_ready[%0d] got %0h exp %0h", k, ret_ready, (k < 4)); end
      set_rec(32'h00000033, 32'h80002000 + 32'(4*k), 1'b0, 1'b1, 5'(11+k), 32'h200 + 32'(k), 1'b0, 5'd0, 32'd0);
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_noemit[%0d] got %0h exp 0", k, valid); end
    end
    ret_valid = 1'b0;
    checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %0h exp 0", ret_ready); end
    trace_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_order = exp_order + 64'd1;
      checks++; if (valid !== 1'b1 || order !== exp_order) begin errors++; $display("FAIL drain_emit[%0d] got valid=%0h order=%0h exp 1/%0h", k, valid, order, exp_order); end
      checks++; if (x_wb !== (32'h1 << (11+k))) begin errors++; $display("FAIL drain_xwb[%0d] got %0h exp %0h", k, x_wb, 32'h1 << (11+k)); end
      checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL drain_ready[%0d] got %0h exp 1", k, ret_ready); end
    end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drain_end got %0h exp 0", valid); end
    checks++; if (xreg(14) !== 32'h203 || xreg(15) !== 32'h0) begin errors++; $display("FAIL drain_shadow got x14=%0h x15=%0h exp 203/0", xreg(14), xreg(15)); end
  endtask

  task automatic test_write_filter();
    set_rec(32'h00000073, 32'h80003000, 1'b1, 1'b1, 5'd3, 32'hBAD, 1'b1, 5'd3, 32'hBAD);
    tick();
    exp_order = exp_order + 64'd1;
    checks++; if (valid !== 1'b1 || order !== exp_order || trap !== 1'b1) begin errors++; $display("FAIL trap_emit got valid=%0h order=%0h trap=%0h exp 1/%0h/1", valid, order, trap, exp_order); end
    checks++; if (x_wb !== '0 || f_wb !== '0) begin errors++; $display("FAIL trap_wb got xwb=%0h fwb=%0h exp 0/0", x_wb, f_wb); end
    checks++; if (xreg(3) !== 32'h102 || freg(3) !== 32'h0) begin errors++; $display("FAIL trap_shadow got x3=%0h f3=%0h exp 102/0", xreg(3), freg(3)); end
    set_rec(32'h00000013, 32'h80003004, 1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    tick();
    ret_valid = 1'b0;
    exp_order = exp_order + 64'd1;
    checks++; if (valid !== 1'b1 || order !== exp_order || trap !== 1'b0) begin errors++; $display("FAIL x0_emit got valid=%0h order=%0h trap=%0h exp 1/%0h/0", valid, order, trap, exp_order); end
    checks++; if (x_wb !== '0 || xreg(0) !== 32'h0) begin errors++; $display("FAIL x0_write got xwb=%0h x0=%0h exp 0/0", x_wb, xreg(0)); end
  endtask

  task automatic test_dual_write();
    set_rec(32'h00000053, 32'h80004000, 1'b0, 1'b1, 5'd2, 32'h11, 1'b1, 5'd0, 32'h3F800000);
    tick();
    ret_valid = 1'b0;
    exp_order = exp_order + 64'd1;
    checks++; if (x_wb !== 32'h4 || f_wb !== 32'h1) begin errors++; $display("FAIL dual_wb got xwb=%0h fwb=%0h exp 4/1", x_wb, f_wb); end
    checks++; if (xreg(2) !== 32'h11 || freg(0) !== 32'h3F800000) begin errors++; $display("FAIL dual_shadow got x2=%0h f0=%0h exp 11/3f800000", xreg(2), freg(0)); end
    checks++; if (order !== exp_order) begin errors++; $display("FAIL dual_order got %0h exp %0h", order, exp_order); end
  endtask

  task automatic test_reset_mid();
    logic [NUM_REGS*XLEN-1:0] exp_x;
    trace_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_rec(32'h00000093, 32'h80005000 + 32'(4*k), 1'b0, 1'b1, 5'(20+k), 32'h300 + 32'(k), 1'b0, 5'd0, 32'd0);
      tick();
    end
    ret_valid = 1'b0;
    trace_stall = 1'b0;
    tick();
    checks++; if (valid !== 1'b1 || x_wb !== (32'h1 << 20)) begin errors++; $display("FAIL rstmid_pre got valid=%0h xwb=%0h exp 1/%0h", valid, x_wb, 32'h1 << 20); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || ret_ready !== 1'b0 || x_wb !== '0 || f_wb !== '0) begin errors++; $display("FAIL rstmid_drop got valid=%0h ready=%0h xwb=%0h fwb=%0h exp 0", valid, ret_ready, x_wb, f_wb); end
    checks++; if (order !== 64'd0 || x_wdata !== '0 || f_wdata !== '0) begin errors++; $display("FAIL rstmid_clear got order=%0h exp 0 with zero shadows", order); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_noemit[%0d] got %0h exp 0", k, valid); end
    end
    set_rec(32'h00700293, 32'h80000000, 1'b0, 1'b1, 5'd5, 32'd7, 1'b0, 5'd0, 32'd0);
    tick();
    ret_valid = 1'b0;
    exp_x = '0;
    exp_x[5*XLEN +: XLEN] = 32'd7;
    checks++; if (valid !== 1'b1 || order !== 64'd1) begin errors++; $display("FAIL rstmid_first got valid=%0h order=%0h exp 1/1", valid, order); end
    checks++; if (x_wdata !== exp_x || f_wdata !== '0) begin errors++; $display("FAIL rstmid_shadow got x=%0h f=%0h exp x=%0h f=0", x_wdata, f_wdata, exp_x); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_drain();
    test_write_filter();
    test_dual_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
